// File: rtl/lmc1992_rx.sv
// Purpose : LMC1992 microwire control receiver with per-channel volume attenuation of
//           an 8-bit offset-binary stereo stream.
// Latency : control frame acts in the LATCH cycle after mw_en_n rises;
//           audio_out is registered two clk32 cycles after audio_ce.
// Backpres: none; every audio_ce produces exactly one out_valid pulse.
// Ports   : clk32/resb (clock, async active-low reset); mw_clk/mw_data/mw_en_n (async
//           microwire); audio_in_l/r + audio_ce in; audio_out_l/r + out_valid out;
//           master_vol/left_vol/right_vol/bass/treble/mix decoded registers;
//           cmd_strobe pulses for each accepted frame.
// Config  : define LMC1992_VOLUME_EN to build the attenuation datapath; without it
//           audio passes through unchanged with the same timing.
module lmc1992_rx (
    input  logic       clk32,
    input  logic       resb,
    input  logic       mw_clk,
    input  logic       mw_data,
    input  logic       mw_en_n,
    input  logic [7:0] audio_in_l,
    input  logic [7:0] audio_in_r,
    input  logic       audio_ce,
    output logic [7:0] audio_out_l,
    output logic [7:0] audio_out_r,
    output logic       out_valid,
    output logic [5:0] master_vol,
    output logic [4:0] left_vol,
    output logic [4:0] right_vol,
    output logic [3:0] bass,
    output logic [3:0] treble,
    output logic [1:0] mix,
    output logic       cmd_strobe
);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t      state, state_nxt;
    logic [2:0]  clk_sr, en_sr;
    logic [1:0]  dat_sr;
    logic [10:0] shreg;
    logic [3:0]  bit_cnt;
    logic        shift_en, cnt_clr;
    logic        clk_rise, en_fall, en_rise;

    // Two synchronizer flops plus one history flop for edge detection. The enable
    // chain resets to 0 (asserted) so that a line still held low across reset is not
    // mistaken for a new frame start: a fresh high-to-low transition is required.
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            clk_sr <= 3'b000;
            en_sr  <= 3'b000;
            dat_sr <= 2'b00;
        end else begin
            clk_sr <= {clk_sr[1:0], mw_clk};
            en_sr  <= {en_sr[1:0], mw_en_n};
            dat_sr <= {dat_sr[0], mw_data};
        end
    end

    assign clk_rise = clk_sr[1] & ~clk_sr[2];
    assign en_fall  = ~en_sr[1] & en_sr[2];
    assign en_rise  = en_sr[1] & ~en_sr[2];

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) state <= IDLE;
        else       state <= state_nxt;
    end

    // A clock edge coinciding with the closing enable edge is still shifted in, so
    // LATCH sees the final bit.
    always_comb begin
        state_nxt  = state;
        shift_en   = 1'b0;
        cnt_clr    = 1'b0;
        cmd_strobe = 1'b0;
        case (state)
            IDLE: begin
                if (en_fall) begin
                    state_nxt = SHIFT;
                    cnt_clr   = 1'b1;
                end
            end
            SHIFT: begin
                shift_en = clk_rise;
                if (en_rise) state_nxt = LATCH;
            end
            LATCH: begin
                state_nxt  = IDLE;
                cmd_strobe = (bit_cnt >= 4'd11) && (shreg[10:9] == 2'b10);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (cnt_clr) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            shreg <= {shreg[9:0], dat_sr[1]};
            if (bit_cnt != 4'd15) bit_cnt <= bit_cnt + 4'd1;
        end
    end

    // Register decode with write-time clamping; func 110/111 strobe but change nothing.
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            master_vol <= 6'd40;
            left_vol   <= 5'd20;
            right_vol  <= 5'd20;
            bass       <= 4'd6;
            treble     <= 4'd6;
            mix        <= 2'd1;
        end else if (cmd_strobe) begin
            case (shreg[8:6])
                3'b000: mix        <= shreg[1:0];
                3'b001: bass       <= (shreg[3:0] > 4'd12) ? 4'd12 : shreg[3:0];
                3'b010: treble     <= (shreg[3:0] > 4'd12) ? 4'd12 : shreg[3:0];
                3'b011: master_vol <= (shreg[5:0] > 6'd40) ? 6'd40 : shreg[5:0];
                3'b100: right_vol  <= (shreg[4:0] > 5'd20) ? 5'd20 : shreg[4:0];
                3'b101: left_vol   <= (shreg[4:0] > 5'd20) ? 5'd20 : shreg[4:0];
                default: ;
            endcase
        end
    end

    // Audio pipeline: stage 1 captures samples (and the attenuation in force at
    // audio_ce), stage 2 registers the result.
    logic [7:0] smp_l, smp_r;
    logic       ce_d;

`ifdef LMC1992_VOLUME_EN
    logic [6:0] atten_l, atten_r;

    // Attenuation in 2 dB steps; both volumes are clamped so this never underflows.
    function automatic logic [6:0] atten_of(input logic [5:0] mv, input logic [4:0] sv);
        return (7'd40 - {1'b0, mv}) + (7'd20 - {2'b00, sv});
    endfunction

    // Fractional gain covers the 0/2/4 dB remainder, the shift covers each 6 dB step.
    // |s*g| <= 128*256 fits 16 signed bits, so prod[15:8] is exactly floor(s*g/256).
    function automatic logic [7:0] attenuate(input logic [7:0] smp, input logic [6:0] atten);
        logic signed [7:0]  s;
        logic signed [9:0]  g;
        logic signed [15:0] prod;
        logic signed [7:0]  p;
        logic signed [7:0]  y;
        logic [6:0]         q;
        s = smp ^ 8'h80;
        q = atten / 7'd3;
        case (atten % 7'd3)
            7'd0:    g = 10'sd256;
            7'd1:    g = 10'sd203;
            default: g = 10'sd161;
        endcase
        prod = s * g;
        p    = prod[15:8];
        y    = (q >= 7'd8) ? 8'sd0 : (p >>> q[2:0]);
        return y ^ 8'h80;
    endfunction
`endif

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            ce_d  <= 1'b0;
            smp_l <= 8'h80;
            smp_r <= 8'h80;
`ifdef LMC1992_VOLUME_EN
            atten_l <= '0;
            atten_r <= '0;
`endif
        end else begin
            ce_d <= audio_ce;
            if (audio_ce) begin
                smp_l <= audio_in_l;
                smp_r <= audio_in_r;
`ifdef LMC1992_VOLUME_EN
                atten_l <= atten_of(master_vol, left_vol);
                atten_r <= atten_of(master_vol, right_vol);
`endif
            end
        end
    end

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            out_valid   <= 1'b0;
            audio_out_l <= 8'h80;
            audio_out_r <= 8'h80;
        end else begin
            out_valid <= ce_d;
            if (ce_d) begin
`ifdef LMC1992_VOLUME_EN
                audio_out_l <= attenuate(smp_l, atten_l);
                audio_out_r <= attenuate(smp_r, atten_r);
`else
                audio_out_l <= smp_l;
                audio_out_r <= smp_r;
`endif
            end
        end
    end

endmodule

// File: doc/lmc1992_rx.md
LMC1992_RX -- requirements
Module: lmc1992_rx

Interface
REQ-001 SHALL have port clk32 in 1: the single system clock; all state is clocked on its rising edge.
REQ-002 SHALL have port resb in 1: reset, asynchronous assertion, active-low.
REQ-003 SHALL have port mw_clk in 1: microwire serial clock, asynchronous to clk32.
REQ-004 SHALL have port mw_data in 1: microwire serial data, asynchronous to clk32.
REQ-005 SHALL have port mw_en_n in 1: microwire frame enable, active-low, asynchronous to clk32.
REQ-006 SHALL have ports audio_in_l and audio_in_r, each in 8: offset-binary samples (0x80 = silence).
REQ-007 SHALL have port audio_ce in 1: one-clk32 pulse marking a new input sample pair.
REQ-008 SHALL have ports audio_out_l and audio_out_r, each out 8: offset-binary attenuated samples.
REQ-009 SHALL have port out_valid out 1: one-cycle pulse when audio_out_l/audio_out_r update.
REQ-010 SHALL have ports master_vol out 6, left_vol out 5, right_vol out 5, bass out 4, treble out 4 and mix out 2: the decoded registers.
REQ-011 SHALL have port cmd_strobe out 1: one-cycle pulse when a frame is accepted.

Function
REQ-012 SHALL pass mw_clk, mw_data and mw_en_n through 2-flop synchronizers, then detect edges on the synchronized copies.
REQ-013 SHALL operate its receive FSM in state IDLE until mw_en_n falls, then enter state SHIFT, clearing the bit counter.
REQ-014 In SHIFT, on each synchronized mw_clk rising edge, SHALL shift mw_data into the LSB of an 11-bit register (MSB first), with the bit counter saturating at 15.
REQ-015 On mw_en_n rising in SHIFT, SHALL enter state LATCH for one cycle, then return to IDLE.
REQ-016 In LATCH, SHALL accept the frame only if the count is >= 11 and shreg[10:9] == 2'b10; when more than 11 bits were sent, the last 11 bits are used.
REQ-017 On acceptance, SHALL decode func = shreg[8:6] and d = shreg[5:0]:
  - 000: mix <= d[1:0]
  - 001: bass <= d[3:0]
  - 010: treble <= d[3:0]
  - 011: master_vol <= d
  - 100: right_vol <= d[4:0]
  - 101: left_vol <= d[4:0]
  - 110/111: no register change
REQ-018 SHALL clamp values on write: master_vol to at most 40, left_vol/right_vol to at most 20, bass/treble to at most 12.
REQ-019 SHALL pulse cmd_strobe in the LATCH cycle for every accepted frame, including func 110/111; rejected frames produce no pulse and no change.
REQ-020 SHALL, when mw_en_n rises in IDLE, take no action.
REQ-021 SHALL, when mw_clk and mw_en_n edges are detected in the same cycle, process the clock edge first.
REQ-022 SHALL tolerate mw_clk high and low times of 4 clk32 cycles or longer.
REQ-023 SHALL compute per-channel attenuation as atten = (40 - master_vol) + (20 - side_vol), in 2 dB units, range 0..60.
REQ-024 SHALL compute each sample as s = audio_in ^ 0x80 (signed), p = (s * g) >>> 8 with g = 256/203/161 for atten mod 3 = 0/1/2, then y = p >>> (atten / 3).
REQ-025 SHALL force y = 0 when atten/3 >= 8, and SHALL use arithmetic (floor) shifts throughout.
REQ-026 SHALL set audio_out = y ^ 0x80, registered two clk32 cycles after audio_ce, with out_valid pulsing in that cycle.
REQ-027 SHALL use the volume registers sampled at audio_ce; a write during the pipeline affects only the next sample.
REQ-028 SHALL hold bass, treble and mix as status outputs only, with no effect on the audio path.

Reset
REQ-029 While resb is low, SHALL hold:
  - FSM = IDLE, bit counter = 0, shreg = 0
  - master_vol = 40, left_vol = 20, right_vol = 20
  - bass = 6, treble = 6, mix = 1
  - audio_out_l = audio_out_r = 0x80
  - out_valid = 0, cmd_strobe = 0
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; after release, the FSM waits in IDLE for a fresh mw_en_n falling edge.

Configuration
REQ-031 With macro LMC1992_VOLUME_EN defined, the attenuation datapath of REQ-023..REQ-027 SHALL be compiled in.
REQ-032 Without LMC1992_VOLUME_EN, audio_out SHALL equal audio_in with the same 2-cycle latency and out_valid timing; register decoding and cmd_strobe are unchanged.

Verification
REQ-033 Volume frame: send 11-bit frame 0x54A (left_vol = 10) at 1 MHz -> cmd_strobe once, left_vol = 10; then audio_in_l = 0xC0 with audio_ce -> audio_out_l = 0x86 two cycles later.
REQ-034 Clamp and full scale: send frame 0x4FF (master 63) -> master_vol = 40; with left_vol = 20, audio_in_l = 0x40 -> audio_out_l = 0x40.
REQ-035 Bad address: send frame 0x2E8 (address 01) -> no cmd_strobe, all registers unchanged.
REQ-036 Long and short frames: send 16-bit 0xFC4C (last 11 bits 0x44C, bass = 12) -> bass = 12; send a 10-bit frame -> rejected.
REQ-037 Reset mid-frame: pulse resb low after 5 bits -> all registers return to reset values; the next complete frame decodes correctly.
REQ-038 Mute: master_vol = 0 and left_vol = 0 -> audio_out_l = 0x80 for any input; with LMC1992_VOLUME_EN undefined, output equals input.
